// File: rtl/key_cmd_ctrl.sv
// rtl/key_cmd_ctrl.sv - turns decoded PS/2 key events into move pulses and pause/flip levels
//
// Optional feature macro: KEY_CMD_AUTOREPEAT_EN
//   defined   : held direction keys auto-repeat (REPEAT_DELAY, then every REPEAT_PERIOD)
//   undefined : one move pulse per direction make; repeat parameters are unused
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   key_valid    in   one-cycle strobe; last_change is valid this cycle
//   last_change  in   [8:0] scan code of the key that just changed
//   key_down     in   [511:0] held state of every scan code
//   move         out  [3:0] one-hot one-cycle pulses {right, left, down, up}
//   pause        out  pause level, toggled by P
//   flip         out  [1:0] {vertical, horizontal} flip levels, toggled by V / H
module key_cmd_ctrl #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [3:0]   move,
  output logic         pause,
  output logic [1:0]   flip
);

  localparam logic [8:0] KEY_W = 9'h1D;
  localparam logic [8:0] KEY_S = 9'h1B;
  localparam logic [8:0] KEY_A = 9'h1C;
  localparam logic [8:0] KEY_D = 9'h23;
  localparam logic [8:0] KEY_P = 9'h4D;
  localparam logic [8:0] KEY_H = 9'h33;
  localparam logic [8:0] KEY_V = 9'h2A;

  logic       is_make;
  logic       dir_hit;
  logic [1:0] dir_new;
  logic       move_start;

  always_comb begin
    is_make = key_valid & key_down[last_change];
    dir_hit = 1'b1;
    dir_new = 2'd0;
    case (last_change)
      KEY_W:   dir_new = 2'd0;
      KEY_S:   dir_new = 2'd1;
      KEY_A:   dir_new = 2'd2;
      KEY_D:   dir_new = 2'd3;
      default: dir_hit = 1'b0;
    endcase
  end

  // Direction makes are swallowed entirely while paused.
  assign move_start = is_make & dir_hit & ~pause;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

`ifdef KEY_CMD_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       dir_q;
  logic [8:0]       dir_code;
  logic             abort;

  always_comb begin
    case (dir_q)
      2'd0:    dir_code = KEY_W;
      2'd1:    dir_code = KEY_S;
      2'd2:    dir_code = KEY_A;
      default: dir_code = KEY_D;
    endcase
    // Leaving the repeat path beats a counter expiry in the same cycle.
    abort = ~key_down[dir_code]
          | (key_valid & ~key_down[last_change] & (last_change == dir_code))
          | pause;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move    <= 4'b0000;
      pause   <= 1'b0;
      flip    <= 2'b00;
`ifdef KEY_CMD_AUTOREPEAT_EN
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 2'd0;
`endif
    end else begin
      move <= 4'b0000;
      if (is_make && last_change == KEY_P) pause   <= ~pause;
      if (is_make && last_change == KEY_H) flip[0] <= ~flip[0];
      if (is_make && last_change == KEY_V) flip[1] <= ~flip[1];
`ifdef KEY_CMD_AUTOREPEAT_EN
      if (move_start) begin
        // A fresh make always restarts, abandoning any older held direction.
        dir_q   <= dir_new;
        move    <= dir_onehot(dir_new);
        cnt_q   <= DELAY_LD;
        state_q <= S_DELAY;
      end else if (state_q != S_IDLE) begin
        if (abort) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else if (cnt_q == '0) begin
          move    <= dir_onehot(dir_q);
          cnt_q   <= PERIOD_LD;
          state_q <= S_REPEAT;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
`else
      if (move_start) move <= dir_onehot(dir_new);
`endif
    end
  end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// tb/tb_key_cmd_ctrl.sv - directed table and sequence bench for key_cmd_ctrl
module tb_key_cmd_ctrl;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   move;
  logic         pause;
  logic [1:0]   flip;

  int checks;
  int failures;

  localparam logic [8:0] KW = 9'h1D;
  localparam logic [8:0] KS = 9'h1B;
  localparam logic [8:0] KA = 9'h1C;
  localparam logic [8:0] KD = 9'h23;
  localparam logic [8:0] KP = 9'h4D;
  localparam logic [8:0] KH = 9'h33;
  localparam logic [8:0] KV = 9'h2A;
  localparam logic [8:0] KX = 9'h15;

  key_cmd_ctrl #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .CNT_W        (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .last_change(last_change),
    .key_down   (key_down),
    .move       (move),
    .pause      (pause),
    .flip       (flip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [8:0] code;
    logic       down;
    logic [3:0] mv;
    logic       ps;
    logic [1:0] fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_vec(input logic kv, input logic [8:0] code, input logic down,
                                  input logic [3:0] mv, input logic ps, input logic [1:0] fl);
    vec_t v;
    v.kv = kv; v.code = code; v.down = down; v.mv = mv; v.ps = ps; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  // One cycle: present an event (or nothing), clock it, sample 1 time unit later.
  task automatic step(input logic kv, input logic [8:0] code, input logic down);
    key_valid   = kv;
    last_change = code;
    if (kv) key_down[code] = down;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  function automatic logic [3:0] exp_auto(input int oc);
`ifdef KEY_CMD_AUTOREPEAT_EN
    if (oc == 1 || (oc >= 9 && oc <= 29 && (oc - 9) % 4 == 0)) return 4'b0001;
`else
    if (oc == 1) return 4'b0001;
`endif
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_switch(input int oc);
    if (oc == 1) return 4'b0100;
    if (oc == 5) return 4'b1000;
`ifdef KEY_CMD_AUTOREPEAT_EN
    if (oc >= 13 && (oc - 13) % 4 == 0) return 4'b1000;
`endif
    return 4'b0000;
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    key_valid   = 1'b0;
    last_change = 9'h000;
    key_down    = '0;

    // Reset held with random inputs.
    for (int c = 0; c < 5; c++) begin
      key_valid   = 1'($urandom);
      last_change = 9'($urandom);
      for (int w = 0; w < 16; w++) key_down[w*32 +: 32] = $urandom;
      @(posedge clk);
      #1;
      chk("rst_move", c, move, 4'h0);
      chk("rst_pause", c, {3'b0, pause}, 4'h0);
      chk("rst_flip", c, {2'b0, flip}, 4'h0);
    end
    key_valid = 1'b0;
    key_down  = '0;
    rst       = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 9'h000, 1'b0);
      chk("post_rst_move", c, move, 4'h0);
      chk("post_rst_pause", c, {3'b0, pause}, 4'h0);
      chk("post_rst_flip", c, {2'b0, flip}, 4'h0);
    end

    // Single-cycle event table: outputs one cycle after each row.
    vecs.push_back(mk_vec(1'b0, 9'h000, 1'b0, 4'h0, 1'b0, 2'b00));
    vecs.push_back(mk_vec(1'b1, KH, 1'b1, 4'h0, 1'b0, 2'b01));
    vecs.push_back(mk_vec(1'b1, KH, 1'b0, 4'h0, 1'b0, 2'b01));
    vecs.push_back(mk_vec(1'b1, KV, 1'b1, 4'h0, 1'b0, 2'b11));
    vecs.push_back(mk_vec(1'b1, KH, 1'b1, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KX, 1'b1, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KW, 1'b1, 4'h1, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b0, 9'h000, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KW, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KP, 1'b1, 4'h0, 1'b1, 2'b10));
    vecs.push_back(mk_vec(1'b1, KS, 1'b1, 4'h0, 1'b1, 2'b10));
    vecs.push_back(mk_vec(1'b1, KS, 1'b0, 4'h0, 1'b1, 2'b10));
    vecs.push_back(mk_vec(1'b1, KP, 1'b0, 4'h0, 1'b1, 2'b10));
    vecs.push_back(mk_vec(1'b1, KP, 1'b1, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KA, 1'b1, 4'h4, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KD, 1'b1, 4'h8, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KA, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KD, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KP, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KW, 1'b1, 4'h1, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KS, 1'b1, 4'h2, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KW, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KS, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KV, 1'b0, 4'h0, 1'b0, 2'b10));
    vecs.push_back(mk_vec(1'b1, KH, 1'b0, 4'h0, 1'b0, 2'b10));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].down);
      chk("tbl_move", i, move, vecs[i].mv);
      chk("tbl_pause", i, {3'b0, pause}, {3'b0, vecs[i].ps});
      chk("tbl_flip", i, {2'b0, flip}, {2'b0, vecs[i].fl});
    end

    // Hold W for 30 cycles, then release and watch for silence.
    for (int c = 0; c <= 40; c++) begin
      if (c == 0)       step(1'b1, KW, 1'b1);
      else if (c == 30) step(1'b1, KW, 1'b0);
      else              step(1'b0, 9'h000, 1'b0);
      chk("auto_move", c + 1, move, exp_auto(c + 1));
    end

    // A held, D made on top: A is abandoned.
    for (int c = 0; c <= 23; c++) begin
      if (c == 0)       step(1'b1, KA, 1'b1);
      else if (c == 4)  step(1'b1, KD, 1'b1);
      else if (c == 22) step(1'b1, KD, 1'b0);
      else if (c == 23) step(1'b1, KA, 1'b0);
      else              step(1'b0, 9'h000, 1'b0);
      chk("switch_move", c + 1, move, (c >= 22) ? 4'h0 : exp_switch(c + 1));
    end

    // Pause blocks a make; unpausing with S still held yields nothing.
    for (int c = 0; c <= 25; c++) begin
      if (c == 0)       step(1'b1, KP, 1'b1);
      else if (c == 5)  step(1'b1, KS, 1'b1);
      else if (c == 10) step(1'b1, KP, 1'b0);
      else if (c == 15) step(1'b1, KP, 1'b1);
      else              step(1'b0, 9'h000, 1'b0);
      chk("pause_move", c + 1, move, 4'h0);
      chk("pause_lvl", c + 1, {3'b0, pause}, (c + 1 <= 15) ? 4'h1 : 4'h0);
    end
    step(1'b1, KS, 1'b0);
    step(1'b1, KP, 1'b0);
    chk("pause_end", 0, {3'b0, pause}, 4'h0);

    // Asynchronous reset in the middle of a held D.
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) step(1'b1, KD, 1'b1);
      else        step(1'b0, 9'h000, 1'b0);
`ifdef KEY_CMD_AUTOREPEAT_EN
      chk("hold_d_move", c + 1, move, (c + 1 == 1 || c + 1 == 9) ? 4'h8 : 4'h0);
`else
      chk("hold_d_move", c + 1, move, (c + 1 == 1) ? 4'h8 : 4'h0);
`endif
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_move", 0, move, 4'h0);
    chk("async_rst_pause", 0, {3'b0, pause}, 4'h0);
    chk("async_rst_flip", 0, {2'b0, flip}, 4'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 9'h000, 1'b0);
      chk("after_rst_move", c, move, 4'h0);
    end
    step(1'b1, KD, 1'b0);
    chk("final_move", 0, move, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
